mitchell_lut_builder: RTL and testbench
=======================================

MITCHELL_LUT_BUILDER -- requirements
Module: mitchell_lut_builder

Interface
REQ-001 Parameter ROUND_EN, default 1: 1 = round-to-nearest region average; 0 = truncate.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin a full 8x8 table build; sampled only in IDLE.
REQ-005 busy  output  1  high in every state except IDLE.
REQ-006 done  output  1  one-cycle pulse after the last table write.
REQ-007 wr_en  output  1  table write strobe; one cycle per entry.
REQ-008 wr_addr  output  6  table address {row[2:0], col[2:0]}.
REQ-009 wr_data  output  10  correction value for the addressed region.
REQ-010 pair_vld  output  1  pair_err is valid this cycle.
REQ-011 pair_err  output  12  exact-minus-Mitchell error of the pair issued in the previous cycle.

Function
REQ-012 The block SHALL generate the 64-entry correction table read by the ETM datapath, where entry {row,col} covers a in [16*row, 16*row+15] and b in [16*col, 16*col+15] (7-bit operands).
REQ-013 FSM states SHALL be IDLE, SWEEP, DRAIN, WRITE, DONE.
REQ-014 IDLE->SWEEP when start=1; region=0, i=j=0, acc=0.
REQ-015 SWEEP SHALL issue one pair per cycle: a=16*row+i, b=16*col+j, with j incrementing fastest and i incrementing when j wraps 15->0; 256 pairs per region; after the pair (i=15,j=15) -> DRAIN.
REQ-016 Mitchell approximation: for a=0 or b=0, P=0. Otherwise a=2^k1+m1, b=2^k2+m2, S=(m1<<k2)+(m2<<k1). If S<2^(k1+k2), P=2^(k1+k2)+S; else P=2*S.
REQ-017 pair_err SHALL equal a*b-P, registered one cycle after issue, with pair_vld=1; it is never negative.
REQ-018 acc (20 bits) SHALL add pair_err on every cycle with pair_vld=1; no overflow is possible (max 256*4095).
REQ-019 DRAIN SHALL last one cycle (the final pair_vld), then go to WRITE.
REQ-020 WRITE SHALL assert wr_en for exactly one cycle, with wr_addr={row,col}.
REQ-021 wr_data SHALL be min(1023, (acc+128)>>8) when ROUND_EN=1, or min(1023, acc>>8) when ROUND_EN=0.
REQ-022 After WRITE: if region=63 -> DONE; otherwise region+1, acc=0, i=j=0, -> SWEEP.
REQ-023 Region order SHALL be row-major (col fastest): region index = {row,col}.
REQ-024 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-025 start SHALL be ignored in every state except IDLE.
REQ-026 Timing, with start sampled at cycle 0:
- SWEEP for region r covers cycles 1+258r .. 256+258r.
- WRITE occurs at cycle 258+258r.
- Last write is at cycle 16512; done is high at cycle 16513; IDLE from cycle 16514.
REQ-027 Outside WRITE: wr_en=0, and wr_addr/wr_data hold their last values. pair_vld=0 outside cycles that follow an issue.

Reset
REQ-028 rst=1 SHALL force IDLE on the next edge with region=0, i=j=0, acc=0, busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0, pair_vld=0, pair_err=0.
REQ-029 rst SHALL take priority over start and over any in-flight state. A reset mid-build SHALL issue no further writes; a new start restarts at region 0.

Verification
REQ-030 Timing: assert start for one cycle at cycle 0 -> busy=1 from cycle 1; wr_en at cycles 258, 516, ..., 16512 with wr_addr 0, 1, ..., 63; done=1 only at cycle 16513; busy=0 at cycle 16514.
REQ-031 Datapath, region 0: pair (3,3) -> pair_err=1 (9-8). Pair (5,7) -> pair_err=3 (35-32). Pairs (0,x) -> pair_err=0. Pair (1,1) -> pair_err=0.
REQ-032 Table values: all 64 wr_data values SHALL match a bench golden model of REQ-016..021 under both ROUND_EN=1 and ROUND_EN=0; wr_data never exceeds 1023.
REQ-033 Ignored start: pulse start at cycles 100 and 16513 -> no restart, no change to the write schedule, IDLE reached at cycle 16514.
REQ-034 Reset mid-build: rst=1 at cycle 600 (inside region 2 SWEEP) -> wr_en=0 and busy=0 from cycle 601. A new start then produces its first write to wr_addr=0, 258 cycles after that start.
REQ-035 Back-to-back builds: start at cycle 16514 -> second build repeats an identical write sequence (addresses and data).

Source files
------------

// File: rtl/mitchell_lut_if.sv
// mitchell_lut_if: control, table-write and pair-error signals of the Mitchell LUT builder
interface mitchell_lut_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [9:0]  wr_data;
  logic        pair_vld;
  logic [11:0] pair_err;
  modport master(output start, input busy, done, wr_en, wr_addr, wr_data, pair_vld, pair_err);
  modport slave(input start, output busy, done, wr_en, wr_addr, wr_data, pair_vld, pair_err);
endinterface

// File: rtl/mitchell_lut_builder.sv
// mitchell_lut_builder: sweeps all 64 operand regions and writes the average Mitchell error per region
module mitchell_lut_builder #(
  parameter bit ROUND_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  mitchell_lut_if.slave lut_io
);
  typedef enum logic [2:0] {IDLE, SWEEP, DRAIN, WRITE, DONE} state_t;
  state_t      state_q, state_d;
  logic [5:0]  region_q, region_d;
  logic [3:0]  i_q, i_d, j_q, j_d;
  logic [19:0] acc_q, acc_d;
  logic        pair_vld_q, pair_vld_d, wr_en_q, wr_en_d;
  logic [11:0] pair_err_q, pair_err_d, err;
  logic [5:0]  wr_addr_q, wr_addr_d;
  logic [9:0]  wr_data_q, wr_data_d;
  logic [6:0]  a, b;
  logic [2:0]  k1, k2;
  logic [13:0] m1, m2, s, e, p;
  logic [12:0] avg;
  function automatic logic [2:0] msb(input logic [6:0] x);
    msb = '0;
    for (int n = 0; n < 7; n++) if (x[n]) msb = 3'(n);
  endfunction
  always_comb begin
    a = {region_q[5:3], i_q};
    b = {region_q[2:0], j_q};
    k1 = msb(a);
    k2 = msb(b);
    m1 = 14'(a) - (14'd1 << k1);
    m2 = 14'(b) - (14'd1 << k2);
    s = (m1 << k2) + (m2 << k1);
    e = 14'd1 << (4'(k1) + 4'(k2));
    p = (a == '0 || b == '0) ? 14'd0 : (s < e ? e + s : s << 1);
    err = 12'(14'(a) * 14'(b) - p);
  end
  always_comb begin
    state_d = state_q;
    region_d = region_q;
    i_d = i_q;
    j_d = j_q;
    acc_d = pair_vld_q ? acc_q + 20'(pair_err_q) : acc_q;
    pair_vld_d = 1'b0;
    pair_err_d = pair_err_q;
    wr_en_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    avg = 13'((21'(acc_d) + (ROUND_EN ? 21'd128 : 21'd0)) >> 8);
    case (state_q)
      IDLE: if (lut_io.start) begin
        state_d = SWEEP;
        region_d = '0;
        i_d = '0;
        j_d = '0;
        acc_d = '0;
      end
      SWEEP: begin
        pair_vld_d = 1'b1;
        pair_err_d = err;
        {i_d, j_d} = {i_q, j_q} + 8'd1;
        state_d = ({i_q, j_q} == 8'hff) ? DRAIN : SWEEP;
      end
      DRAIN: begin
        state_d = WRITE;
        wr_en_d = 1'b1;
        wr_addr_d = region_q;
        wr_data_d = (avg > 13'd1023) ? 10'd1023 : avg[9:0];
      end
      WRITE: begin
        acc_d = '0;
        state_d = (region_q == 6'd63) ? DONE : SWEEP;
        region_d = (region_q == 6'd63) ? region_q : region_q + 6'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      region_q <= '0;
      i_q <= '0;
      j_q <= '0;
      acc_q <= '0;
      pair_vld_q <= 1'b0;
      pair_err_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      region_q <= region_d;
      i_q <= i_d;
      j_q <= j_d;
      acc_q <= acc_d;
      pair_vld_q <= pair_vld_d;
      pair_err_q <= pair_err_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
  assign lut_io.busy = state_q != IDLE;
  assign lut_io.done = state_q == DONE;
  assign lut_io.wr_en = wr_en_q;
  assign lut_io.wr_addr = wr_addr_q;
  assign lut_io.wr_data = wr_data_q;
  assign lut_io.pair_vld = pair_vld_q;
  assign lut_io.pair_err = pair_err_q;
endmodule

// File: tb/tb_mitchell_lut_builder.sv
// tb_mitchell_lut_builder: scoreboard bench running truncating and rounding builders side by side
module tb_mitchell_lut_builder;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  int cyc = 0, checks = 0, errors = 0;
  int gold[2][64];
  typedef struct {int cyc; int addr; int data;} wexp_t;
  typedef struct {int cyc; int err;} pexp_t;
  wexp_t wq[2][$];
  pexp_t pq[2][$];
  int dq[2][$];
  logic busy[2], done[2], wr_en[2], pair_vld[2];
  logic [5:0] wr_addr[2];
  logic [9:0] wr_data[2];
  logic [11:0] pair_err[2];
  mitchell_lut_if b0();
  mitchell_lut_if b1();
  mitchell_lut_builder #(.ROUND_EN(1'b0)) u0 (.clk(clk), .rst(rst), .lut_io(b0.slave));
  mitchell_lut_builder #(.ROUND_EN(1'b1)) u1 (.clk(clk), .rst(rst), .lut_io(b1.slave));
  assign b0.start = start;
  assign b1.start = start;
  assign busy[0] = b0.busy;
  assign busy[1] = b1.busy;
  assign done[0] = b0.done;
  assign done[1] = b1.done;
  assign wr_en[0] = b0.wr_en;
  assign wr_en[1] = b1.wr_en;
  assign wr_addr[0] = b0.wr_addr;
  assign wr_addr[1] = b1.wr_addr;
  assign wr_data[0] = b0.wr_data;
  assign wr_data[1] = b1.wr_data;
  assign pair_vld[0] = b0.pair_vld;
  assign pair_vld[1] = b1.pair_vld;
  assign pair_err[0] = b0.pair_err;
  assign pair_err[1] = b1.pair_err;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;
  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d at cycle %0d: got %0d expected %0d", nm, d, cyc, act, exp);
    end
  endtask
  function automatic int mitch(input int a, input int b);
    int ka, kb, fa, fb, s;
    if (a == 0 || b == 0) return 0;
    ka = 0;
    kb = 0;
    while ((2 << ka) <= a) ka++;
    while ((2 << kb) <= b) kb++;
    fa = a - (1 << ka);
    fb = b - (1 << kb);
    s = fa * (1 << kb) + fb * (1 << ka);
    return (s < (1 << (ka + kb))) ? (1 << (ka + kb)) + s : 2 * s;
  endfunction
  initial begin
    for (int r = 0; r < 64; r++) begin
      int sum;
      sum = 0;
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++) begin
          int a, b;
          a = 16 * (r / 8) + i;
          b = 16 * (r % 8) + j;
          sum += a * b - mitch(a, b);
        end
      gold[0][r] = (sum / 256 > 1023) ? 1023 : sum / 256;
      gold[1][r] = ((sum + 128) / 256 > 1023) ? 1023 : (sum + 128) / 256;
    end
  end
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      wexp_t w;
      pexp_t p;
      int dc;
      if (wr_en[d]) begin
        if (wq[d].size() == 0) chk("unexpected_write", d, 1, 0);
        else begin
          w = wq[d].pop_front();
          chk("write_cycle", d, cyc, w.cyc);
          chk("wr_addr", d, int'(wr_addr[d]), w.addr);
          chk("wr_data", d, int'(wr_data[d]), w.data);
        end
      end
      if (pq[d].size() > 0 && pq[d][0].cyc == cyc) begin
        p = pq[d].pop_front();
        chk("pair_vld", d, int'(pair_vld[d]), 1);
        chk("pair_err", d, int'(pair_err[d]), p.err);
      end
      if (done[d]) begin
        if (dq[d].size() == 0) chk("unexpected_done", d, 1, 0);
        else begin
          dc = dq[d].pop_front();
          chk("done_cycle", d, cyc, dc);
        end
      end
    end
  end
  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask
  task automatic push_build(input int c0);
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 64; r++) wq[d].push_back('{c0 + 258 + 258 * r, r, gold[d][r]});
      dq[d].push_back(c0 + 16513);
      pq[d].push_back('{c0 + 7, 0});
      pq[d].push_back('{c0 + 19, 0});
      pq[d].push_back('{c0 + 53, 1});
      pq[d].push_back('{c0 + 89, 3});
    end
  endtask
  task automatic chk_idle_regs(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk({nm, "_busy"}, d, int'(busy[d]), 0);
      chk({nm, "_done"}, d, int'(done[d]), 0);
      chk({nm, "_wr_en"}, d, int'(wr_en[d]), 0);
      chk({nm, "_wr_addr"}, d, int'(wr_addr[d]), 0);
      chk({nm, "_wr_data"}, d, int'(wr_data[d]), 0);
      chk({nm, "_pair_vld"}, d, int'(pair_vld[d]), 0);
      chk({nm, "_pair_err"}, d, int'(pair_err[d]), 0);
    end
  endtask
  task automatic chk_empty(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk({nm, "_writes_left"}, d, wq[d].size(), 0);
      chk({nm, "_done_left"}, d, dq[d].size(), 0);
      chk({nm, "_pairs_left"}, d, pq[d].size(), 0);
    end
  endtask
  initial begin
    int c0, c1, c2, c3;
    repeat (3) @(negedge clk);
    chk_idle_regs("reset");
    rst = 1'b0;
    @(negedge clk);
    c0 = cyc;
    start = 1'b1;
    push_build(c0);
    @(negedge clk);
    start = 1'b0;
    for (int d = 0; d < 2; d++) chk("busy_after_start", d, int'(busy[d]), 1);
    wait_to(c0 + 100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_to(c0 + 16513);
    start = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("idle_after_done", d, int'(busy[d]), 0);
    c1 = cyc;
    push_build(c1);
    @(negedge clk);
    start = 1'b0;
    for (int d = 0; d < 2; d++) chk("busy_second_build", d, int'(busy[d]), 1);
    wait_to(c1 + 16515);
    chk_empty("two_builds");
    c2 = cyc;
    start = 1'b1;
    push_build(c2);
    @(negedge clk);
    start = 1'b0;
    wait_to(c2 + 600);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_regs("mid_reset");
    for (int d = 0; d < 2; d++) begin
      chk("writes_before_reset", d, 64 - wq[d].size(), 2);
      wq[d].delete();
      dq[d].delete();
      pq[d].delete();
    end
    repeat (20) @(negedge clk);
    c3 = cyc;
    start = 1'b1;
    for (int d = 0; d < 2; d++) wq[d].push_back('{c3 + 258, 0, gold[d][0]});
    @(negedge clk);
    start = 1'b0;
    wait_to(c3 + 260);
    chk_empty("restart");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
